// File: rtl/fill_bus_arbiter_if.sv
// rtl/fill_bus_arbiter_if.sv - request, fill-field and output-beat bundle for fill_bus_arbiter
`timescale 1ns/1ps
interface fill_bus_arbiter_if #(
    parameter int WIDTH = 40,
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     mode;
    logic [2*NREQ-1:0]     lit;
    logic [NREQ-1:0]       bit_in;
    logic [LEN_W*NREQ-1:0] len;
    logic [NREQ-1:0]       grant;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic                  busy;

    modport master (
        output req, mode, lit, bit_in, len, out_ready,
        input  grant, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  req, mode, lit, bit_in, len, out_ready,
        output grant, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/fill_bus_arbiter.sv
// rtl/fill_bus_arbiter.sv - round-robin constant-fill burst arbiter; FILL_ARB_FIXED_PRIO_EN selects fixed priority
`timescale 1ns/1ps
module fill_bus_arbiter #(
    parameter int WIDTH = 40,
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    fill_bus_arbiter_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [PTR_W-1:0] win;
    logic [1:0]       sel_mode;
    logic [1:0]       sel_lit;
    logic             sel_bit;
    logic [LEN_W-1:0] sel_len;
    logic [WIDTH-1:0] fill;

`ifdef FILL_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) win = PTR_W'(i);
        end
    end
`else
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] cand;
    logic             hit;

    // Search upward from the pointer with wrap; first set request wins.
    always_comb begin
        win  = '0;
        cand = '0;
        hit  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NREQ);
            if (!hit && bus.req[cand]) begin
                win = cand;
                hit = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_mode = bus.mode[2*int'(win) +: 2];
        sel_lit  = bus.lit[2*int'(win) +: 2];
        sel_bit  = bus.bit_in[win];
        sel_len  = bus.len[LEN_W*int'(win) +: LEN_W];
        fill     = '0;
        case (sel_mode)
            2'b00:   fill = '0;
            2'b01:   fill = '1;
            2'b10:   fill = {{(WIDTH-2){sel_lit[1]}}, sel_lit};
            default: fill = {{(WIDTH-1){1'b0}}, sel_bit};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.grant     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
`ifndef FILL_ARB_FIXED_PRIO_EN
            ptr           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state         <= BURST;
                        cnt           <= sel_len;
                        bus.grant     <= NREQ'(1) << win;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= fill;
                        bus.out_last  <= (sel_len == '0);
                        bus.busy      <= 1'b1;
`ifndef FILL_ARB_FIXED_PRIO_EN
                        ptr           <= (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
                    end
                end
                BURST: begin
                    // Everything holds under backpressure; the word never changes mid-burst.
                    if (bus.out_ready) begin
                        if (bus.out_last) begin
                            state         <= IDLE;
                            bus.grant     <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_data  <= '0;
                            bus.out_last  <= 1'b0;
                            bus.busy      <= 1'b0;
                        end else begin
                            cnt          <= cnt - 1'b1;
                            bus.out_last <= (cnt == LEN_W'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fill_bus_arbiter.sv
// tb/tb_fill_bus_arbiter.sv - scoreboard bench for fill_bus_arbiter
`timescale 1ns/1ps
module tb_fill_bus_arbiter;
    localparam int WIDTH = 40;
    localparam int NREQ  = 4;
    localparam int LEN_W = 4;
    localparam int MW    = 2 * NREQ;
    localparam int LW    = LEN_W * NREQ;

    typedef struct {
        logic [NREQ-1:0]  grant;
        logic [WIDTH-1:0] data;
        logic             last;
        logic             first;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fill_bus_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W)) bus ();
    fill_bus_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t            q[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    int               last_cyc = -100;
    int               mptr = 0;
    bit               ready_rand = 1'b0;
    logic             stalled = 1'b0;
    logic [WIDTH-1:0] h_data;
    logic             h_last;
    logic [NREQ-1:0]  h_grant;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ready_rand) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [WIDTH-1:0] fill_word(int m, int l, int b);
        int v;
        case (m)
            0: return '0;
            1: return '1;
            2: begin
                v = (l >= 2) ? l - 4 : l;
                return WIDTH'(longint'(v));
            end
            default: return WIDTH'(b);
        endcase
    endfunction

    function automatic int pick(logic [NREQ-1:0] r);
        int i;
        for (int k = 0; k < NREQ; k++) begin
`ifdef FILL_ARB_FIXED_PRIO_EN
            i = k;
`else
            i = (mptr + k) % NREQ;
`endif
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic expect_burst(input logic [NREQ-1:0] r);
        int w, m, l, b, n;
        beat_t e;
        w = pick(r);
        if (w < 0) return;
        m = int'(bus.mode[2*w +: 2]);
        l = int'(bus.lit[2*w +: 2]);
        b = int'(bus.bit_in[w]);
        n = int'(bus.len[LEN_W*w +: LEN_W]);
        for (int k = 0; k <= n; k++) begin
            e.grant = NREQ'(1) << w;
            e.data  = fill_word(m, l, b);
            e.last  = (k == n);
            e.first = (k == 0);
            q.push_back(e);
        end
        mptr = (w + 1) % NREQ;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_fields(input int i, input int m, input int l, input int b, input int n);
        bus.mode[2*i +: 2]         = 2'(m);
        bus.lit[2*i +: 2]          = 2'(l);
        bus.bit_in[i]              = 1'(b);
        bus.len[LEN_W*i +: LEN_W]  = LEN_W'(n);
    endtask

    task automatic scramble();
        bus.mode   = MW'($urandom);
        bus.lit    = MW'($urandom);
        bus.bit_in = NREQ'($urandom);
        bus.len    = LW'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: busy=%b still set after %0d cycles, required 0", name, bus.busy, n);
        end
    endtask

    // Called at posedge+1 with the arbiter idle; fields change right after the grant edge.
    task automatic issue(input logic [NREQ-1:0] r);
        logic [NREQ-1:0] bi;
        bus.req = r;
        expect_burst(r);
        @(posedge clk); #1;
        bus.req = '0;
        if (r == '0) begin
            chk("no_req_idle", 64'(bus.busy), 64'(0));
        end else begin
            bi = bus.bit_in;
            scramble();
            bus.bit_in = ~bi;
            wait_idle("burst_end");
        end
    endtask

    // Scoreboard monitor: compares every accepted beat and checks hold-under-stall.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== h_data ||
                    bus.out_last !== h_last || bus.grant !== h_grant) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b grant=%b required valid=1 data=%h last=%b grant=%b",
                             bus.out_valid, bus.out_data, bus.out_last, bus.grant, h_data, h_last, h_grant);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            h_data  = bus.out_data;
            h_last  = bus.out_last;
            h_grant = bus.grant;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: grant=%b data=%h last=%b, none required",
                             bus.grant, bus.out_data, bus.out_last);
                end else begin
                    e = q.pop_front();
                    if (bus.grant !== e.grant || bus.out_data !== e.data || bus.out_last !== e.last) begin
                        errors++;
                        $display("FAIL beat: grant=%b data=%h last=%b, required grant=%b data=%h last=%b",
                                 bus.grant, bus.out_data, bus.out_last, e.grant, e.data, e.last);
                    end
                    if (e.first) begin
                        checks++;
                        if (cyc - last_cyc < 2) begin
                            errors++;
                            $display("FAIL idle_gap: %0d cycles since last burst, required >= 2", cyc - last_cyc);
                        end
                    end
                    if (e.last) last_cyc = cyc;
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] r;
        rst = 1'b1;
        bus.req = '0; bus.mode = '0; bus.lit = '0; bus.bit_in = '0; bus.len = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(bus.grant), 64'(0));
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_data",  64'(bus.out_data), 64'(0));
        chk("rst_last",  64'(bus.out_last), 64'(0));
        chk("rst_busy",  64'(bus.busy), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        set_fields(0, 1, 0, 0, 0);
        issue(4'b0001);
        chk("idle_grant", 64'(bus.grant), 64'(0));
        chk("idle_valid", 64'(bus.out_valid), 64'(0));

        set_fields(0, 2, 2, 0, 2);
        issue(4'b0001);
        set_fields(0, 3, 0, 1, 1);
        issue(4'b0001);

        // All requesters held: one single-beat burst per grant, pointer rotates.
        for (int i = 0; i < NREQ; i++) set_fields(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1, 0);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) expect_burst(4'b1111);
        repeat (10) begin @(posedge clk); #1; end
        bus.req = '0;
        wait_idle("rr_held");

        // Backpressure after beat 1 of 4.
        set_fields(2, 2, 1, 0, 3);
        bus.req = 4'b0100;
        expect_burst(4'b0100);
        @(posedge clk); #1;
        bus.req = '0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        wait_idle("stall");

        // Reset during beat 2 of 4, then grant restarts from pointer 0.
        set_fields(1, 1, 0, 0, 3);
        bus.req = 4'b0010;
        expect_burst(4'b0010);
        @(posedge clk); #1;
        bus.req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_grant", 64'(bus.grant), 64'(0));
        chk("midrst_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_data",  64'(bus.out_data), 64'(0));
        chk("midrst_last",  64'(bus.out_last), 64'(0));
        chk("midrst_busy",  64'(bus.busy), 64'(0));
        q.delete();
        mptr = 0;
        set_fields(3, 2, 3, 0, 1);
        bus.req = 4'b1010;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_burst(4'b1010);
        @(posedge clk); #1;
        bus.req = '0;
        wait_idle("post_rst");

        ready_rand = 1'b1;
        repeat (60) begin
            scramble();
            r = NREQ'($urandom);
            issue(r);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        ready_rand = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        wait_idle("drain");
        repeat (4) begin @(posedge clk); #1; end
        chk("queue_empty", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
